// File: rtl/div_iter_axis.sv
// Restoring divider, one quotient bit per cycle, answering the ALU divider stream handshake.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and answers in 2 cycles.
module div_iter_axis #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata,
    output logic               m_axis_dout_tvalid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q;
    logic               tready_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;
    logic               sign_q_q;
    logic               sign_r_q;
    logic [2*WIDTH-1:0] dout_tdata_q;
    logic               dout_tvalid_q;

    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     shift;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;

    always_comb begin
        accept = tready_q && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
        a_neg  = SIGNED && s_axis_dividend_tdata[WIDTH-1];
        b_neg  = SIGNED && s_axis_divisor_tdata[WIDTH-1];
        a_abs  = a_neg ? (~s_axis_dividend_tdata + WIDTH'(1)) : s_axis_dividend_tdata;
        b_abs  = b_neg ? (~s_axis_divisor_tdata + WIDTH'(1)) : s_axis_divisor_tdata;
        // Partial remainder stays below the divisor, so W+1 bits hold the shifted value and the sign.
        shift  = {rem_q, quo_q[WIDTH-1]};
        diff   = shift - {1'b0, divisor_q};
        if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        quo_res = sign_q_q ? (~quo_q + WIDTH'(1)) : quo_q;
        rem_res = sign_r_q ? (~rem_q + WIDTH'(1)) : rem_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            tready_q      <= 1'b0;
            cnt_q         <= '0;
            divisor_q     <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            sign_q_q      <= 1'b0;
            sign_r_q      <= 1'b0;
            dout_tdata_q  <= '0;
            dout_tvalid_q <= 1'b0;
        end else begin
            dout_tvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tready_q <= !accept;
                    if (accept) begin
                        divisor_q <= b_abs;
                        quo_q     <= a_abs;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        sign_q_q  <= a_neg ^ b_neg;
                        sign_r_q  <= a_neg;
`ifdef DIV_ZERO_FAST_EN
                        // Same result the full iteration would produce: all-ones magnitude, remainder |a|.
                        if (s_axis_divisor_tdata == '0) begin
                            quo_q   <= '1;
                            rem_q   <= a_abs;
                            state_q <= FIX;
                        end else begin
                            state_q <= CALC;
                        end
`else
                        state_q   <= CALC;
`endif
                    end
                end
                CALC: begin
                    tready_q <= 1'b0;
                    quo_q    <= quo_d;
                    rem_q    <= rem_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    tready_q      <= 1'b0;
                    dout_tdata_q  <= {quo_res, rem_res};
                    dout_tvalid_q <= 1'b1;
                    state_q       <= IDLE;
                end
                default: begin
                    tready_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign s_axis_dividend_tready = tready_q;
    assign s_axis_divisor_tready  = tready_q;
    assign m_axis_dout_tdata      = dout_tdata_q;
    assign m_axis_dout_tvalid     = dout_tvalid_q;

endmodule

// File: tb/tb_div_iter_axis.sv
// Bench for div_iter_axis: signed and unsigned instances, directed corner cases, then random
// back-to-back operations compared against an arithmetic reference model.
module tb_div_iter_axis;

    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = W + 2;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          sel = 1'b0;
    logic [W-1:0]  a_data = '0;
    logic [W-1:0]  b_data = '0;
    logic          vld_a = 1'b0;
    logic          vld_b = 1'b0;

    logic          rdy_a_s, rdy_b_s, vout_s, rdy_a_u, rdy_b_u, vout_u;
    logic [2*W-1:0] dout_s, dout_u;
    logic          tready, dout_v;
    logic [2*W-1:0] dout_d;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    div_iter_axis #(.WIDTH(W), .SIGNED(1'b1)) u_signed (
        .clk(clk), .resetn(resetn),
        .s_axis_dividend_tdata(a_data), .s_axis_dividend_tvalid(vld_a & sel),
        .s_axis_dividend_tready(rdy_a_s),
        .s_axis_divisor_tdata(b_data), .s_axis_divisor_tvalid(vld_b & sel),
        .s_axis_divisor_tready(rdy_b_s),
        .m_axis_dout_tdata(dout_s), .m_axis_dout_tvalid(vout_s)
    );

    div_iter_axis #(.WIDTH(W), .SIGNED(1'b0)) u_unsigned (
        .clk(clk), .resetn(resetn),
        .s_axis_dividend_tdata(a_data), .s_axis_dividend_tvalid(vld_a & ~sel),
        .s_axis_dividend_tready(rdy_a_u),
        .s_axis_divisor_tdata(b_data), .s_axis_divisor_tvalid(vld_b & ~sel),
        .s_axis_divisor_tready(rdy_b_u),
        .m_axis_dout_tdata(dout_u), .m_axis_dout_tvalid(vout_u)
    );

    // Both tready ports must agree; a disagreement reads as not-ready and trips the checks.
    assign tready = sel ? (rdy_a_s & rdy_b_s) : (rdy_a_u & rdy_b_u);
    assign dout_v = sel ? vout_s : vout_u;
    assign dout_d = sel ? dout_s : dout_u;

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [2*W-1:0] ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint la, lb, q, r;
        if (!s) begin
            if (b == 0) return {{W{1'b1}}, a};
            return {a / b, a % b};
        end
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (lb == 0) return {(la < 0) ? W'(1) : {W{1'b1}}, a};
        q = la / lb;
        r = la % lb;
        return {W'(q), W'(r)};
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!tready && n < 100) begin @(negedge clk); n++; end
        chk("ready_wait", (n < 100), 1);
        a_data = a;
        b_data = b;
        vld_a  = 1'b1;
        vld_b  = 1'b1;
        @(negedge clk);
        vld_a  = 1'b0;
        vld_b  = 1'b0;
        a_data = $urandom;
        b_data = $urandom;
    endtask

    task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat = 0;
        bit busy = 1'b0;
        int exp_lat;
        logic [2*W-1:0] exp, got;
        exp     = ref_div(sel, a, b);
        exp_lat = (b == 0) ? ZERO_LAT : W + 2;
        while (!dout_v && lat < 100) begin
            busy |= tready;
            @(negedge clk);
            lat++;
        end
        busy |= tready;
        got = dout_d;
        chk({tag, "_lat"}, lat + 1, exp_lat);
        chk({tag, "_data"}, got, exp);
        chk({tag, "_busy_rdy"}, busy, 0);
        @(negedge clk);
        chk({tag, "_pulse"}, dout_v, 0);
        chk({tag, "_rdy_back"}, tready, 1);
        chk({tag, "_hold"}, dout_d, got);
        $display("%s s=%0d a=%h b=%h -> %h lat=%0d", tag, sel, a, b, got, lat + 1);
    endtask

    task automatic run_op(input string tag, input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        sel = s;
        start_op(a, b);
        finish_op(tag, a, b);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return {W{1'b1}};
            2: return 32'h8000_0000;
            3: return W'($urandom_range(1, 15));
            4: return -W'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit seen;
        bit rdy_ok;
        // Reset values on both instances
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_rdy", tready, 0);
            chk("rst_vld", dout_v, 0);
            chk("rst_data", dout_d, 0);
        end
        resetn = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", tready, 1);

        run_op("u_100_7", 1'b0, 32'd100, 32'd7);
        chk("u_100_7_val", dout_u, {32'h0000_000E, 32'h0000_0002});
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2);
        chk("s_m7_2_val", dout_s, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("s_ovf_val", dout_s, {32'h8000_0000, 32'h0});
        run_op("s_div0", 1'b1, 32'hFFFF_FFF0, 32'h0);
        chk("s_div0_val", dout_s, {32'h0000_0001, 32'hFFFF_FFF0});
        run_op("s_div0p", 1'b1, 32'h0000_0123, 32'h0);
        run_op("u_div0", 1'b0, 32'hDEAD_BEEF, 32'h0);

        // Only the dividend valid: nothing accepted
        sel = 1'b1;
        a_data = 32'd1000; b_data = 32'd3; vld_a = 1'b1; vld_b = 1'b0;
        seen = 1'b0; rdy_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            seen |= dout_v;
            rdy_ok &= tready;
        end
        chk("one_valid_rdy", rdy_ok, 1);
        chk("one_valid_out", seen, 0);
        vld_b = 1'b1;
        @(negedge clk);
        vld_a = 1'b0; vld_b = 1'b0;
        finish_op("late_divisor", 32'd1000, 32'd3);

        // Reset in the middle of an iteration aborts the operation
        sel = 1'b0;
        start_op(32'd12345, 32'd67);
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_rdy", tready, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("midrst_rdy_back", tready, 1);
        seen = 1'b0;
        repeat (40) begin
            seen |= dout_v;
            @(negedge clk);
        end
        chk("midrst_no_out", seen, 0);
        run_op("after_rst", 1'b0, 32'd12345, 32'd67);

        // Random back-to-back operations on both flavours
        for (int i = 0; i < 500; i++) begin
            run_op("rnd", 1'($urandom_range(0, 1)), pick(), pick());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
